// File: rtl/capiano_pkg.sv
// rtl/capiano_pkg.sv - canvas geometry, address layout and scanner state encoding shared by the key detector
package capiano_pkg;

    localparam int CANVAS_ROWS  = 120;
    localparam int CANVAS_COLS  = 160;
    localparam int NUM_KEYS     = 8;
    localparam int COLS_PER_KEY = 20;
    localparam int ADDR_ROW_LSB = 18;
    localparam int ADDR_ROW_W   = 7;
    localparam int ADDR_COL_LSB = 2;
    localparam int ADDR_COL_W   = 8;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        EVAL  = 2'd3
    } kd_state_e;

    // Row lands in [24:18], column in [9:2]; every other bit stays zero.
    function automatic logic [31:0] make_addr(input logic [ADDR_ROW_W-1:0] row,
                                              input logic [ADDR_COL_W-1:0] col);
        return {7'd0, row, 8'd0, col, 2'd0};
    endfunction

endpackage

// File: rtl/pix_dark.sv
// rtl/pix_dark.sv - combinational RGB333 darkness test: R+G+B below DARK_TH
module pix_dark #(
    parameter int DARK_TH = 6
) (
    input  logic [8:0] i_pix,
    output logic       o_dark
);

    logic [4:0] w_sum;

    // Three 3-bit channels top out at 21, so five bits never overflow.
    assign w_sum  = {2'b00, i_pix[8:6]} + {2'b00, i_pix[5:3]} + {2'b00, i_pix[2:0]};
    assign o_dark = (32'(w_sum) < 32'(DARK_TH));

endmodule

// File: rtl/key_detector.sv
// rtl/key_detector.sv - scans a canvas row band, counts dark pixels per key strip, reports pressed keys
// Build option KEY_DEBOUNCE_EN: a key only changes after two consecutive scans agree.
module key_detector
    import capiano_pkg::*;
#(
    parameter int ROW_TOP   = 100,
    parameter int ROW_BOT   = 119,
    parameter int DARK_TH   = 6,
    parameter int PRESS_CNT = 40
) (
    input  logic        mem_clk,
    input  logic        rst,
    input  logic        work_en,
    output logic [31:0] addr,
    input  logic [8:0]  q,
    output logic [7:0]  keys,
    output logic        scan_done,
    output logic        busy
);

    kd_state_e               r_state;
    kd_state_e               w_state_nxt;
    logic [ADDR_ROW_W-1:0]   r_row;
    logic [ADDR_ROW_W-1:0]   w_row_nxt;
    logic [ADDR_COL_W-1:0]   r_col;
    logic [ADDR_COL_W-1:0]   w_col_nxt;
    logic [4:0]              r_sub;
    logic [4:0]              w_sub_nxt;
    logic [2:0]              r_key;
    logic [2:0]              w_key_nxt;
    logic                    r_v0;
    logic                    r_v1;
    logic [2:0]              r_k1;
    logic                    r_drain;
    logic [31:0]             r_addr;
    logic [CNT_W-1:0]        r_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0]     w_raw;
    logic [NUM_KEYS-1:0]     r_keys;
    logic                    r_scan_done;
    logic                    w_dark;
    logic                    w_start;
    logic                    w_last;

    assign w_start = (r_state == IDLE) && work_en;
    assign w_last  = (r_row == 7'(ROW_BOT)) && (r_col == 8'(CANVAS_COLS - 1));

    pix_dark #(
        .DARK_TH (DARK_TH)
    ) u_pix_dark (
        .i_pix  (q),
        .o_dark (w_dark)
    );

    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (work_en) w_state_nxt = READ;
            READ:    if (w_last)  w_state_nxt = DRAIN;
            DRAIN:   if (r_drain) w_state_nxt = EVAL;
            EVAL:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sub-column and key counters step with the column so the key index needs no divide.
    always_comb begin
        w_col_nxt = r_col + 8'd1;
        w_sub_nxt = r_sub + 5'd1;
        w_key_nxt = r_key;
        w_row_nxt = r_row;
        if (r_sub == 5'(COLS_PER_KEY - 1)) begin
            w_sub_nxt = '0;
            w_key_nxt = r_key + 3'd1;
        end
        if (r_col == 8'(CANVAS_COLS - 1)) begin
            w_col_nxt = '0;
            w_sub_nxt = '0;
            w_key_nxt = '0;
            w_row_nxt = r_row + 7'd1;
        end
    end

    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            r_row   <= '0;
            r_col   <= '0;
            r_sub   <= '0;
            r_key   <= '0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_k1    <= '0;
            r_drain <= 1'b0;
            r_addr  <= '0;
        end else begin
            // Stage 0 (r_v0/r_key) rides with r_addr; stage 1 lines up with q one edge later.
            r_v1    <= r_v0;
            r_k1    <= r_key;
            r_drain <= (r_state == DRAIN) ? ~r_drain : 1'b0;
            if (w_start) begin
                r_row  <= 7'(ROW_TOP);
                r_col  <= '0;
                r_sub  <= '0;
                r_key  <= '0;
                r_v0   <= 1'b1;
                r_addr <= make_addr(7'(ROW_TOP), 8'd0);
            end else if (r_state == READ) begin
                if (w_last) begin
                    r_v0 <= 1'b0;
                end else begin
                    r_row  <= w_row_nxt;
                    r_col  <= w_col_nxt;
                    r_sub  <= w_sub_nxt;
                    r_key  <= w_key_nxt;
                    r_addr <= make_addr(w_row_nxt, w_col_nxt);
                end
            end
        end
    end

    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_KEYS; i++) r_cnt[i] <= '0;
        end else if (w_start) begin
            for (int i = 0; i < NUM_KEYS; i++) r_cnt[i] <= '0;
        end else if (r_v1 && w_dark && (r_cnt[r_k1] != {CNT_W{1'b1}})) begin
            r_cnt[r_k1] <= r_cnt[r_k1] + 16'd1;
        end
    end

    always_comb begin
        w_raw = '0;
        for (int i = 0; i < NUM_KEYS; i++) w_raw[i] = (32'(r_cnt[i]) >= 32'(PRESS_CNT));
    end

`ifdef KEY_DEBOUNCE_EN
    logic [NUM_KEYS-1:0] r_prev_raw;
    logic [NUM_KEYS-1:0] w_stable;

    assign w_stable = ~(w_raw ^ r_prev_raw);

    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            r_keys     <= '0;
            r_prev_raw <= '0;
        end else if (r_state == EVAL) begin
            r_keys     <= (r_keys & ~w_stable) | (w_raw & w_stable);
            r_prev_raw <= w_raw;
        end
    end
`else
    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            r_keys <= '0;
        end else if (r_state == EVAL) begin
            r_keys <= w_raw;
        end
    end
`endif

    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= (r_state == EVAL);
        end
    end

    assign addr      = r_addr;
    assign keys      = r_keys;
    assign scan_done = r_scan_done;
    assign busy      = (r_state != IDLE);

endmodule

// File: doc/key_detector.md
KEY_DETECTOR -- requirements
Module: key_detector

Interface
REQ-001 The module SHALL have parameter ROW_TOP, default 100, meaning the first canvas row scanned (0..119).
REQ-002 The module SHALL have parameter ROW_BOT, default 119, meaning the last canvas row scanned (ROW_TOP..119).
REQ-003 The module SHALL have parameter DARK_TH, default 6, meaning a pixel is dark when R+G+B < DARK_TH.
REQ-004 The module SHALL have parameter PRESS_CNT, default 40, meaning the minimum dark-pixel count that marks a key pressed.
REQ-005 The module SHALL have port mem_clk, input, 1 bit, the single clock.
REQ-006 The module SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 The module SHALL have port work_en, input, 1 bit, scan enable.
REQ-008 The module SHALL have port addr, output, 32 bits, canvas read address: row in [24:18], column in [9:2], all other bits 0.
REQ-009 The module SHALL have port q, input, 9 bits, canvas pixel in RGB333 format: R [8:6], G [5:3], B [2:0].
REQ-010 The module SHALL have port keys, output, 8 bits, pressed flag per key; bit i covers columns 20i..20i+19.
REQ-011 The module SHALL have port scan_done, output, 1 bit, one-cycle pulse when keys is updated.
REQ-012 The module SHALL have port busy, output, 1 bit, high while a scan is in progress.

Function
REQ-013 The module SHALL implement FSM states IDLE, READ, DRAIN, EVAL.
- IDLE -> READ when work_en=1.
- READ -> DRAIN after the address for row ROW_BOT, column 159 is issued.
- DRAIN -> EVAL after 2 cycles.
- EVAL -> IDLE after 1 cycle.
REQ-014 In READ the module SHALL issue one address per cycle in row-major order (column 0..159 inner loop, row ROW_TOP..ROW_BOT outer loop), with addr registered.
REQ-015 The module SHALL sample the pixel for an address on the second mem_clk edge after the edge that loaded that address, carrying a 2-stage valid/key-index tag pipeline.
REQ-016 The module SHALL derive the key index from a 0..19 sub-column counter and a 0..7 key counter, using no divider.
REQ-017 The module SHALL keep eight 16-bit saturating dark counters, cleared on the IDLE->READ transition.
REQ-018 The module SHALL form the dark sum as a zero-extended 5-bit R+G+B with no overflow.
REQ-019 In EVAL the module SHALL set raw[i] = (count[i] >= PRESS_CNT), update keys, and assert scan_done for exactly that cycle.
REQ-020 The module SHALL hold busy = 1 in READ, DRAIN and EVAL, and 0 in IDLE.
REQ-021 Deasserting work_en mid-scan SHALL NOT abort the scan; the scan completes and the FSM returns to IDLE.
REQ-022 With work_en held at 1, the next scan SHALL start on the cycle after EVAL; scan period = 160*(ROW_BOT-ROW_TOP+1)+4 cycles (3204 cycles at defaults).
REQ-023 The module SHALL NOT change keys other than in EVAL.

Reset
REQ-024 While rst=0 the module SHALL force keys=0, scan_done=0, busy=0, addr=0, all counters and tags to 0, and state to IDLE.
REQ-025 Reset asserted mid-scan SHALL discard all partial counts, and no scan_done SHALL follow.

Configuration
REQ-026 With KEY_DEBOUNCE_EN defined, keys[i] SHALL take raw[i] only when raw[i] equals raw[i] of the previous scan; prev_raw SHALL reset to 0.
REQ-027 Without KEY_DEBOUNCE_EN, keys SHALL equal raw after every scan, and no prev_raw storage SHALL exist.

Structure
REQ-028 The shared package capiano_pkg SHALL hold the canvas constants: rows 120, columns 160, address row field [24:18], column field [9:2], 8 keys, 20 columns per key.
REQ-029 The design SHALL contain one sub-module, pix_dark: combinational RGB333 sum-and-compare against DARK_TH.

Verification
REQ-030 The bench SHALL check: all-white canvas (q=9'h1FF), work_en=1 -> scan_done after 3204 cycles, keys=8'h00.
REQ-031 The bench SHALL check: columns 20..39 black (q=0) in rows 100..119 -> keys=8'h02 (count 400 >= 40).
REQ-032 The bench SHALL check: column 0 only black in rows 100..119 (count 20) -> keys=8'h00; columns 0..1 black (count 40) -> keys=8'h01.
REQ-033 The bench SHALL check: address ordering and latency by a model returning q = addr[9:2] mod 2 -> per-key counts match reference math; addr[24:18] spans 100..119.
REQ-034 The bench SHALL check: rst pulsed low at cycle 1000 of a scan -> busy=0, keys=0, no scan_done; a fresh scan follows.
REQ-035 The bench SHALL check: with KEY_DEBOUNCE_EN, key 7 black on a single scan only -> keys stays 8'h00; black on two consecutive scans -> 8'h80 after the second.
